// File: rtl/reset_bridge_stretch_if.sv
// reset_bridge_stretch_if: lock/request inputs and conditioned reset outputs; RST_COUNT exists only with RST_BRIDGE_COUNT_EN
interface reset_bridge_stretch_if;
  logic LOCKED;
  logic REQ;
  logic RST_OUT;
  logic RST_DONE;
`ifdef RST_BRIDGE_COUNT_EN
  logic [15:0] RST_COUNT;
  modport master (output LOCKED, REQ, input RST_OUT, RST_DONE, RST_COUNT);
  modport slave (input LOCKED, REQ, output RST_OUT, RST_DONE, RST_COUNT);
`else
  modport master (output LOCKED, REQ, input RST_OUT, RST_DONE);
  modport slave (input LOCKED, REQ, output RST_OUT, RST_DONE);
`endif
endinterface

// File: rtl/reset_bridge_stretch.sv
// reset_bridge_stretch: async-assert/sync-release reset gated by lock and stretched; RST_BRIDGE_COUNT_EN adds RST_COUNT
module reset_bridge_stretch #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter bit IS_C_INVERTED  = 1'b0
) (
  input logic C,
  input logic CLR,
  reset_bridge_stretch_if.slave bus
);
  localparam int CW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(STRETCH_CYCLES - 1);
  typedef enum logic [1:0] {HOLD, STRETCH, RUN} state_t;
  logic                   w_clk;
  logic                   w_hold;
  logic [SYNC_STAGES-1:0] r_chain;
  logic [1:0]             r_lock;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_rst_out;
  logic                   r_rst_done;
  assign w_clk  = C ^ IS_C_INVERTED;
  assign w_hold = r_chain[SYNC_STAGES-1] | ~r_lock[1];
  // release chain: zeros walk in once CLR drops, so release is synchronous to C
  always_ff @(posedge w_clk or posedge CLR)
    if (CLR) r_chain <= '1;
    else r_chain <= r_chain << 1;
  // two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge w_clk or posedge CLR)
    if (CLR) r_lock <= 2'b00;
    else r_lock <= {r_lock[0], bus.LOCKED};
  // HOLD/STRETCH/RUN sequencer; hold conditions override everything, REQ restarts the stretch
  always_ff @(posedge w_clk or posedge CLR)
    if (CLR) begin
      r_state    <= HOLD;
      r_cnt      <= '0;
      r_rst_out  <= 1'b1;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b0;
      if (w_hold) begin
        r_state   <= HOLD;
        r_rst_out <= 1'b1;
      end else if (r_state == HOLD || (r_state == RUN && bus.REQ)) begin
        r_state   <= STRETCH;
        r_cnt     <= RELOAD;
        r_rst_out <= 1'b1;
      end else if (r_state == STRETCH) begin
        if (bus.REQ) r_cnt <= RELOAD;
        else if (r_cnt == '0) begin
          r_state    <= RUN;
          r_rst_out  <= 1'b0;
          r_rst_done <= 1'b1;
        end else r_cnt <= r_cnt - CW'(1);
      end
    end
  assign bus.RST_OUT  = r_rst_out;
  assign bus.RST_DONE = r_rst_done;
`ifdef RST_BRIDGE_COUNT_EN
  logic [15:0] r_count;
  // saturating count of resets re-entered from RUN (soft request or lock loss)
  always_ff @(posedge w_clk or posedge CLR)
    if (CLR) r_count <= '0;
    else if (r_state == RUN && (w_hold || bus.REQ) && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
  assign bus.RST_COUNT = r_count;
`endif
endmodule

// File: tb/tb_reset_bridge_stretch.sv
// tb_reset_bridge_stretch: scoreboard bench, two configurations driven with shared stimulus
module tb_reset_bridge_stretch;
  logic C;
  logic clr;
  logic locked;
  logic req;
  int   total = 0;
  int   pass  = 0;
  reset_bridge_stretch_if b0();
  reset_bridge_stretch_if b1();
  assign b0.LOCKED = locked;
  assign b0.REQ    = req;
  assign b1.LOCKED = locked;
  assign b1.REQ    = req;
  reset_bridge_stretch #(.SYNC_STAGES(2), .STRETCH_CYCLES(16), .IS_C_INVERTED(1'b0)) u0 (.C(C), .CLR(clr), .bus(b0));
  reset_bridge_stretch #(.SYNC_STAGES(4), .STRETCH_CYCLES(1), .IS_C_INVERTED(1'b0)) u1 (.C(C), .CLR(clr), .bus(b1));
  logic [1:0] w_out, w_done;
  assign w_out  = {b1.RST_OUT, b0.RST_OUT};
  assign w_done = {b1.RST_DONE, b0.RST_DONE};
`ifdef RST_BRIDGE_COUNT_EN
  logic [15:0] w_cnt [2];
  assign w_cnt[0] = b0.RST_COUNT;
  assign w_cnt[1] = b1.RST_COUNT;
`endif
  typedef struct { bit out[2]; bit done[2]; int cnt[2]; } exp_t;
  exp_t q[$];
  int ss[2] = '{2, 4};
  int st[2] = '{16, 1};
  int k[2], rel[2], cnt[2];
  bit arm[2];
  bit lk_q[$];
  initial begin
    C = 0;
    forever #5 C = ~C;
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  // reference: edge k since CLR fell; release happens at a deadline set when the hold clears or REQ is seen
  task automatic model_edge(input bit c, input bit l, input bit r);
    exp_t e;
    bit run, hold;
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        k[i] = 0; arm[i] = 1; rel[i] = 0; cnt[i] = 0;
        e.out[i] = 1; e.done[i] = 0; e.cnt[i] = 0;
      end else begin
        k[i]++;
        run  = !arm[i] && rel[i] < k[i];
        hold = k[i] <= ss[i] || k[i] <= 2 || !lk_q[k[i]-3];
        if (run && (hold || r) && cnt[i] < 65535) cnt[i]++;
        if (hold) arm[i] = 1;
        else if (arm[i] || r) begin
          arm[i] = 0;
          rel[i] = k[i] + st[i];
        end
        e.out[i]  = arm[i] || k[i] < rel[i];
        e.done[i] = !arm[i] && k[i] == rel[i];
        e.cnt[i]  = cnt[i];
      end
    end
    q.push_back(e);
    if (c) lk_q.delete();
    else lk_q.push_back(l);
  endtask
  task automatic step(input bit c, input bit l, input bit r);
    clr = c; locked = l; req = r;
    model_edge(c, l, r);
    @(negedge C);
  endtask
  task automatic clr_pulse(input bit l);
    #2 clr = 1; locked = l; req = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async_rst_out[%0d]", i), int'(w_out[i]), 1);
      chk($sformatf("async_rst_done[%0d]", i), int'(w_done[i]), 0);
`ifdef RST_BRIDGE_COUNT_EN
      chk($sformatf("async_rst_count[%0d]", i), int'(w_cnt[i]), 0);
`endif
    end
    model_edge(1, l, 0);
    @(negedge C);
  endtask
  exp_t me;
  int   ec;
  int   fall[2];
  bit   prev[2];
  // monitor: pop one expectation per edge and compare both instances
  initial forever begin
    @(posedge C);
    #1;
    if (q.size() == 0) begin
      total++;
      $display("FAIL scoreboard_empty: got no entry, expected one");
    end else begin
      me = q.pop_front();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rst_out[%0d]@%0t", i, $time), int'(w_out[i]), int'(me.out[i]));
        chk($sformatf("rst_done[%0d]@%0t", i, $time), int'(w_done[i]), int'(me.done[i]));
`ifdef RST_BRIDGE_COUNT_EN
        chk($sformatf("rst_count[%0d]@%0t", i, $time), int'(w_cnt[i]), me.cnt[i]);
`endif
      end
    end
    if (clr) begin
      ec = 0;
      fall[0] = 0;
      fall[1] = 0;
    end else begin
      ec++;
      for (int i = 0; i < 2; i++)
        if (prev[i] && !w_out[i] && fall[i] == 0) fall[i] = ec;
    end
    for (int i = 0; i < 2; i++) prev[i] = w_out[i];
  end
  initial begin
    clr = 1; locked = 1; req = 0;
    #1;
    chk("reset_rst_out0", int'(w_out[0]), 1);
    chk("reset_rst_done0", int'(w_done[0]), 0);
    chk("reset_rst_out1", int'(w_out[1]), 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 0);
    chk("pwrup_fall_edge0", fall[0], 19);
    chk("pwrup_fall_edge1", fall[1], 6);
    clr_pulse(0);
    for (int i = 0; i < 30; i++) step(0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 0);
    chk("latelock_fall_edge0", fall[0], 49);
    chk("latelock_fall_edge1", fall[1], 34);
    step(0, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 25; i++) step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 1);
    for (int i = 0; i < 25; i++) step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    clr_pulse(1);
    for (int i = 0; i < 30; i++) step(0, 1, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) clr_pulse(1);
      else step(0, $urandom_range(0, 39) != 0, $urandom_range(0, 14) == 0);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
